// File: rtl/main_memory_pkg.sv
// main_memory_pkg: shared types, default parameters and address helpers for
// the banked block memory (main_memory_banked, main_memory_array).
package main_memory_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam int DEF_ADDR_W          = 32;
  localparam int DEF_WORD_W          = 32;
  localparam int DEF_WORDS_PER_BLOCK = 4;
  localparam int DEF_DEPTH_BLOCKS    = 256;
  localparam int DEF_LATENCY         = 4;

  // Latency counter width; covers LATENCY up to 15.
  localparam int CNT_W = 4;

  // Number of byte-offset bits inside one block.
  function automatic int calc_off_w(input int words_per_block, input int word_w);
    return $clog2((words_per_block * word_w) / 8);
  endfunction

endpackage

// File: rtl/main_memory_array.sv
// main_memory_array: block storage with one write port, one combinational
// read port and a per-block written bit that is cleared synchronously on rst.
module main_memory_array
  import main_memory_pkg::*;
#(
  parameter int BLOCK_W      = DEF_WORDS_PER_BLOCK * DEF_WORD_W,
  parameter int DEPTH_BLOCKS = DEF_DEPTH_BLOCKS,
  parameter int IDX_W        = $clog2(DEF_DEPTH_BLOCKS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en_i,
  input  logic [IDX_W-1:0]   wr_idx_i,
  input  logic [BLOCK_W-1:0] wr_data_i,
  input  logic [IDX_W-1:0]   rd_idx_i,
  output logic [BLOCK_W-1:0] rd_data_o,
  output logic               rd_written_o
);

  logic [BLOCK_W-1:0]      mem_q [DEPTH_BLOCKS];
  logic [DEPTH_BLOCKS-1:0] written_q;

  // Data storage has no reset; validity is tracked by written_q.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_idx_i] <= wr_data_i;
    end
  end

  // Written bits: cleared on reset, set by each committed write.
  always_ff @(posedge clk) begin
    if (rst) begin
      written_q <= '0;
    end else if (wr_en_i) begin
      written_q[wr_idx_i] <= 1'b1;
    end
  end

  assign rd_data_o    = mem_q[rd_idx_i];
  assign rd_written_o = written_q[rd_idx_i];

endmodule

// File: rtl/main_memory_banked.sv
// main_memory_banked: block-granular memory with a single outstanding request
// and a fixed accept-to-response latency. Unwritten blocks read back as an
// address-derived pattern.
// Optional feature: define MAIN_MEMORY_OOR_CHECK_EN to flag addresses whose
// bits above the block index are nonzero (error response, no write). Without
// it, high address bits alias modulo DEPTH_BLOCKS and resp_err stays 0.
//
// state | meaning
// IDLE  | ready to accept a request
// WAIT  | latency countdown for the captured request
// RESP  | response held until the consumer takes it
module main_memory_banked
  import main_memory_pkg::*;
#(
  parameter int ADDR_W          = DEF_ADDR_W,
  parameter int WORD_W          = DEF_WORD_W,
  parameter int WORDS_PER_BLOCK = DEF_WORDS_PER_BLOCK,
  parameter int DEPTH_BLOCKS    = DEF_DEPTH_BLOCKS,
  parameter int LATENCY         = DEF_LATENCY
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              req_valid,
  output logic                              req_ready,
  input  logic                              req_write,
  input  logic [ADDR_W-1:0]                 req_addr,
  input  logic [WORDS_PER_BLOCK*WORD_W-1:0] req_wdata,
  output logic                              resp_valid,
  input  logic                              resp_ready,
  output logic [WORDS_PER_BLOCK*WORD_W-1:0] resp_rdata,
  output logic                              resp_err
);

  localparam int BLOCK_W = WORDS_PER_BLOCK * WORD_W;
  localparam int OFF_W   = calc_off_w(WORDS_PER_BLOCK, WORD_W);
  localparam int IDX_W   = $clog2(DEPTH_BLOCKS);
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((1 << OFF_W) - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ready_q;

  logic               write_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [BLOCK_W-1:0] wdata_q;
  logic [BLOCK_W-1:0] rdata_q;
  logic               err_q;

  logic               accept;
  logic               finish;
  logic               oor;
  logic               arr_wr_en;
  logic               arr_written;
  logic [IDX_W-1:0]   blk_idx;
  logic [ADDR_W-1:0]  blk_base;
  logic [BLOCK_W-1:0] arr_rdata;
  logic [BLOCK_W-1:0] pattern;
  logic [BLOCK_W-1:0] rdata_d;

  assign accept   = req_valid && req_ready;
  assign finish   = (state_q == ST_WAIT) && (cnt_q == '0) && !rst;
  assign blk_idx  = addr_q[OFF_W +: IDX_W];
  assign blk_base = addr_q & ~OFF_MASK;

`ifdef MAIN_MEMORY_OOR_CHECK_EN
  assign oor = (addr_q >> (OFF_W + IDX_W)) != '0;
`else
  assign oor = 1'b0;
`endif

  assign arr_wr_en = finish && write_q && !oor;

  // State register, latency counter and registered ready flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= (state_d == ST_IDLE);
    end
  end

  // Next-state and counter logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_WAIT;
          cnt_d   = CNT_W'(LATENCY - 1);
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_RESP: begin
        if (resp_valid && resp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Handshake and response outputs, forced quiet while reset is held.
  always_comb begin
    req_ready  = ready_q && !rst;
    resp_valid = (state_q == ST_RESP) && !rst;
    resp_rdata = rst ? '0 : rdata_q;
    resp_err   = rst ? 1'b0 : err_q;
  end

  // Pattern block for never-written blocks: block base byte address plus word number.
  always_comb begin
    pattern = '0;
    for (int i = 0; i < WORDS_PER_BLOCK; i++) begin
      pattern[i*WORD_W +: WORD_W] = WORD_W'(blk_base + ADDR_W'(i));
    end
  end

  // Response data selected at the WAIT->RESP edge.
  always_comb begin
    if (write_q || oor) begin
      rdata_d = '0;
    end else if (arr_written) begin
      rdata_d = arr_rdata;
    end else begin
      rdata_d = pattern;
    end
  end

  // Request capture on accept and response capture at end of countdown.
  always_ff @(posedge clk) begin
    if (rst) begin
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (accept) begin
        write_q <= req_write;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
      if (finish) begin
        rdata_q <= rdata_d;
        err_q   <= oor;
      end
    end
  end

  main_memory_array #(
    .BLOCK_W      (BLOCK_W),
    .DEPTH_BLOCKS (DEPTH_BLOCKS),
    .IDX_W        (IDX_W)
  ) u_array (
    .clk          (clk),
    .rst          (rst),
    .wr_en_i      (arr_wr_en),
    .wr_idx_i     (blk_idx),
    .wr_data_i    (wdata_q),
    .rd_idx_i     (blk_idx),
    .rd_data_o    (arr_rdata),
    .rd_written_o (arr_written)
  );

endmodule

// File: tb/tb_main_memory_banked.sv
// tb_main_memory_banked: directed scenarios plus randomized traffic checked
// against a block-level reference model (associative array of written blocks).
module tb_main_memory_banked;

  localparam int ADDR_W = 32;
  localparam int WORD_W = 32;
  localparam int WPB    = 4;
  localparam int DEPTH  = 256;
  localparam int LAT    = 4;
  localparam int BLK_W  = WPB * WORD_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [BLK_W-1:0]  req_wdata;
  logic              resp_valid;
  logic              resp_ready;
  logic [BLK_W-1:0]  resp_rdata;
  logic              resp_err;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [BLK_W-1:0] mem_model [int];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  main_memory_banked #(
    .ADDR_W          (ADDR_W),
    .WORD_W          (WORD_W),
    .WORDS_PER_BLOCK (WPB),
    .DEPTH_BLOCKS    (DEPTH),
    .LATENCY         (LAT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err)
  );

  // ---------------- reference model ----------------
  function automatic bit model_oor(input logic [ADDR_W-1:0] a);
`ifdef MAIN_MEMORY_OOR_CHECK_EN
    return (a / 32'h1000) != 0;
`else
    return 1'b0;
`endif
  endfunction

  function automatic int model_idx(input logic [ADDR_W-1:0] a);
    return int'((a / 16) % DEPTH);
  endfunction

  function automatic logic [BLK_W-1:0] model_pattern(input logic [ADDR_W-1:0] a);
    logic [BLK_W-1:0]  b;
    logic [ADDR_W-1:0] base;
    base = (a / 16) * 16;
    for (int i = 0; i < WPB; i++) b[i*WORD_W +: WORD_W] = base + ADDR_W'(i);
    return b;
  endfunction

  function automatic logic [BLK_W-1:0] model_read(input logic [ADDR_W-1:0] a);
    if (model_oor(a)) return '0;
    if (mem_model.exists(model_idx(a))) return mem_model[model_idx(a)];
    return model_pattern(a);
  endfunction

  // One full transaction; caller is aligned at posedge+1. Updates the model on write commit.
  task automatic run_txn(input logic w, input logic [ADDR_W-1:0] a, input logic [BLK_W-1:0] wd,
                         input int hold, output logic [BLK_W-1:0] rd, output logic er,
                         output int lat, output bit ok);
    int n;
    ok = 1'b1; rd = '0; er = 1'b0; lat = 0;
    n = 0;
    while (!req_ready && n < 20) begin @(posedge clk); #1; n++; end
    if (!req_ready) begin ok = 1'b0; return; end
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 0;
    while (!resp_valid && n < 40) begin @(posedge clk); #1; n++; end
    if (!resp_valid) begin ok = 1'b0; return; end
    lat = n; rd = resp_rdata; er = resp_err;
    repeat (hold) begin @(posedge clk); #1; end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    if (w && !model_oor(a)) mem_model[model_idx(a)] = wd;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    resp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (req_ready !== 1'b0 || resp_valid !== 1'b0 || resp_rdata !== '0 || resp_err !== 1'b0) begin
      bad++;
      $display("FAIL reset_outputs: ready=%b valid=%b rdata=%h err=%b, want 0 0 0 0",
               req_ready, resp_valid, resp_rdata, resp_err);
    end
    rst = 1'b0;
    mem_model.delete();
    total++;
    if (req_ready !== 1'b0) begin
      bad++; $display("FAIL reset_release_ready_early: ready=%b want 0", req_ready);
    end
    @(posedge clk); #1;
    total++;
    if (req_ready !== 1'b1) begin
      bad++; $display("FAIL reset_release_ready: ready=%b want 1", req_ready);
    end
  endtask

  task automatic test_pattern_read();
    logic [BLK_W-1:0] rd; logic er; int lat; bit ok;
    run_txn(1'b0, 32'h0000_0104, '0, 0, rd, er, lat, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL pattern_read_timeout: ok=%0d want 1", ok); end
    total++;
    if (lat !== LAT) begin bad++; $display("FAIL pattern_read_latency: got %0d want %0d", lat, LAT); end
    total++;
    if (rd !== {32'h103, 32'h102, 32'h101, 32'h100} || er !== 1'b0) begin
      bad++; $display("FAIL pattern_read_data: got %h err=%b want 00000103000001020000010100000100 err=0", rd, er);
    end
  endtask

  task automatic test_write_read();
    logic [BLK_W-1:0] rd; logic er; int lat; bit ok;
    logic [BLK_W-1:0] wd;
    wd = {32'hD, 32'hC, 32'hB, 32'hA};
    run_txn(1'b1, 32'h200, wd, 0, rd, er, lat, ok);
    total++;
    if (!ok || rd !== '0 || er !== 1'b0 || lat !== LAT) begin
      bad++; $display("FAIL write_resp: ok=%0d rdata=%h err=%b lat=%0d want 1 0 0 %0d", ok, rd, er, lat, LAT);
    end
    run_txn(1'b0, 32'h20C, '0, 1, rd, er, lat, ok);
    total++;
    if (!ok || rd !== wd || er !== 1'b0) begin
      bad++; $display("FAIL write_then_read: ok=%0d rdata=%h err=%b want %h err=0", ok, rd, er, wd);
    end
  endtask

  task automatic test_backpressure();
    logic [BLK_W-1:0] exp, first; int n;
    exp = model_read(32'h208);
    total++;
    if (req_ready !== 1'b1) begin bad++; $display("FAIL bp_idle_ready: ready=%b want 1", req_ready); end
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h208;
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 0;
    while (!resp_valid && n < 40) begin @(posedge clk); #1; n++; end
    first = resp_rdata;
    total++;
    if (resp_valid !== 1'b1 || first !== exp) begin
      bad++; $display("FAIL bp_first_resp: valid=%b rdata=%h want 1 %h", resp_valid, first, exp);
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      total++;
      if (resp_valid !== 1'b1 || resp_rdata !== first || req_ready !== 1'b0) begin
        bad++; $display("FAIL bp_hold_%0d: valid=%b rdata=%h ready=%b want 1 %h 0",
                        i, resp_valid, resp_rdata, req_ready, first);
      end
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    total++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      bad++; $display("FAIL bp_handshake_idle: valid=%b ready=%b want 0 1", resp_valid, req_ready);
    end
  endtask

  task automatic test_oor();
    logic [BLK_W-1:0] rd, exp; logic er; int lat; bit ok;
    exp = model_read(32'h0001_0000);
    run_txn(1'b0, 32'h0001_0000, '0, 0, rd, er, lat, ok);
    total++;
    if (!ok || rd !== exp || er !== model_oor(32'h0001_0000)) begin
      bad++; $display("FAIL oor_read: ok=%0d rdata=%h err=%b want %h err=%b",
                      ok, rd, er, exp, model_oor(32'h0001_0000));
    end
    run_txn(1'b1, 32'h0001_0200, {4{32'h5555_AAAA}}, 0, rd, er, lat, ok);
    total++;
    if (!ok || rd !== '0 || er !== model_oor(32'h0001_0200)) begin
      bad++; $display("FAIL oor_write_resp: ok=%0d rdata=%h err=%b want 0 err=%b",
                      ok, rd, er, model_oor(32'h0001_0200));
    end
    exp = model_read(32'h200);
    run_txn(1'b0, 32'h200, '0, 0, rd, er, lat, ok);
    total++;
    if (!ok || rd !== exp || er !== 1'b0) begin
      bad++; $display("FAIL oor_alias_check: ok=%0d rdata=%h err=%b want %h err=0", ok, rd, er, exp);
    end
  endtask

  task automatic test_reset_mid();
    logic [BLK_W-1:0] rd; logic er; int lat; bit ok; bit quiet;
    quiet = 1'b1;
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h300; req_wdata = {4{32'hDEAD_BEEF}};
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    total++;
    if (req_ready !== 1'b0 || resp_valid !== 1'b0) begin
      bad++; $display("FAIL midrst_held: ready=%b valid=%b want 0 0", req_ready, resp_valid);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    mem_model.delete();
    for (int i = 0; i < LAT + 3; i++) begin
      if (resp_valid !== 1'b0) quiet = 1'b0;
      @(posedge clk); #1;
    end
    total++;
    if (!quiet) begin bad++; $display("FAIL midrst_no_resp: saw resp_valid=1 want none"); end
    total++;
    if (req_ready !== 1'b1) begin bad++; $display("FAIL midrst_ready: ready=%b want 1", req_ready); end
    run_txn(1'b0, 32'h300, '0, 0, rd, er, lat, ok);
    total++;
    if (!ok || rd !== {32'h303, 32'h302, 32'h301, 32'h300} || er !== 1'b0) begin
      bad++; $display("FAIL midrst_pattern: ok=%0d rdata=%h err=%b want 00000303000003020000030100000300 err=0",
                      ok, rd, er);
    end
  endtask

  task automatic test_back_to_back();
    int acc[$];
    logic [BLK_W-1:0] exp;
    exp = model_read(32'h500);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h500; resp_ready = 1'b1;
    for (int i = 0; i < 4 * (LAT + 2) + 1; i++) begin
      @(negedge clk);
      if (req_ready) acc.push_back(cyc);
      if (resp_valid) begin
        total++;
        if (resp_rdata !== exp || resp_err !== 1'b0) begin
          bad++; $display("FAIL b2b_data: rdata=%h err=%b want %h err=0", resp_rdata, resp_err, exp);
        end
      end
    end
    req_valid = 1'b0;
    repeat (LAT + 4) @(negedge clk);
    resp_ready = 1'b0;
    @(posedge clk); #1;
    total++;
    if (acc.size() < 4) begin bad++; $display("FAIL b2b_accept_count: got %0d want >=4", acc.size()); end
    for (int i = 1; i < acc.size(); i++) begin
      total++;
      if (acc[i] - acc[i-1] != LAT + 2) begin
        bad++; $display("FAIL b2b_period_%0d: got %0d want %0d", i, acc[i] - acc[i-1], LAT + 2);
      end
    end
  endtask

  task automatic test_random();
    logic [BLK_W-1:0] rd, exp, wd; logic er, w, exp_err; int lat; bit ok;
    logic [ADDR_W-1:0] a;
    for (int t = 0; t < 40; t++) begin
      w = 1'(($urandom_range(0, 1)));
      a = ADDR_W'($urandom_range(0, 7)) * 16 + ADDR_W'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) a = a + ADDR_W'($urandom_range(1, 32'hFFFFF)) * 32'h1000;
      for (int i = 0; i < WPB; i++) wd[i*WORD_W +: WORD_W] = $urandom;
      exp     = w ? '0 : model_read(a);
      exp_err = model_oor(a);
      run_txn(w, a, wd, $urandom_range(0, 2), rd, er, lat, ok);
      total++;
      if (!ok || lat != LAT) begin
        bad++; $display("FAIL rand_%0d_timing: ok=%0d lat=%0d want 1 %0d", t, ok, lat, LAT);
      end
      total++;
      if (rd !== exp || er !== exp_err) begin
        bad++; $display("FAIL rand_%0d_data: w=%b addr=%h rdata=%h err=%b want %h err=%b",
                        t, w, a, rd, er, exp, exp_err);
      end
    end
  endtask

  initial begin
    test_reset();
    test_pattern_read();
    test_write_read();
    test_backpressure();
    test_oor();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, bench did not complete");
    $fatal(1);
  end

endmodule

// File: doc/main_memory_banked.md
MAIN_MEMORY_BANKED -- requirements
Module: main_memory_banked

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, byte-address width.
REQ-002 SHALL have parameter WORD_W, default 32, word width in bits.
REQ-003 SHALL have parameter WORDS_PER_BLOCK, default 4, power of 2, words per block.
REQ-004 SHALL have parameter DEPTH_BLOCKS, default 256, power of 2, blocks stored.
REQ-005 SHALL have parameter LATENCY, default 4, range 1..15, accept-to-response cycles.
REQ-006 SHALL have port clk, input, 1, sole clock; all logic on its rising edge.
REQ-007 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-008 SHALL have port req_valid, input, 1, request present.
REQ-009 SHALL have port req_ready, output, 1, block can accept a request.
REQ-010 SHALL have port req_write, input, 1, 1 = block write, 0 = block read.
REQ-011 SHALL have port req_addr, input, ADDR_W, byte address; offset bits are ignored.
REQ-012 SHALL have port req_wdata, input, WORDS_PER_BLOCK*WORD_W, write block; word i in bits [i*WORD_W +: WORD_W].
REQ-013 SHALL have port resp_valid, output, 1, response present.
REQ-014 SHALL have port resp_ready, input, 1, consumer takes the response.
REQ-015 SHALL have port resp_rdata, output, WORDS_PER_BLOCK*WORD_W, read block; 0 for writes.
REQ-016 SHALL have port resp_err, output, 1, error flag (see Configuration).

Function
REQ-017 SHALL use an FSM with states IDLE, WAIT and RESP.
REQ-018 SHALL hold req_ready = 1 only in IDLE; a request is accepted when req_valid && req_ready.
REQ-019 SHALL, on accept, capture write, address and wdata, load the latency counter with LATENCY-1, and go to WAIT.
REQ-020 SHALL decrement the counter in WAIT and go to RESP when it is 0, so resp_valid first rises exactly LATENCY cycles after the accept edge.
REQ-021 SHALL hold resp_valid, resp_rdata and resp_err stable in RESP until resp_valid && resp_ready, then return to IDLE on that edge.
REQ-022 SHALL form the block index as addr[OFF_W +: IDX_W], where OFF_W = log2(WORDS_PER_BLOCK*WORD_W/8) and IDX_W = log2(DEPTH_BLOCKS).
REQ-023 SHALL commit a write to the array on the WAIT->RESP edge and set that block's written bit.
REQ-024 SHALL return stored data on a read when the written bit is set.
REQ-025 SHALL, when the written bit is clear, return a pattern block: word i = {addr[ADDR_W-1:OFF_W], OFF_W'b0} + i, truncated or zero-extended to WORD_W.
REQ-026 SHALL let a read issued after a completed write to the same block return the written data; no hazard is possible because only one request is ever outstanding.

Reset
REQ-027 SHALL, while rst = 1, drive req_ready = 0, resp_valid = 0, resp_rdata = 0 and resp_err = 0, clear the counter and all written bits, and set the state to IDLE.
REQ-028 SHALL drop any in-flight request on reset mid-operation without committing it, and SHALL raise req_ready on the first edge after rst deasserts.

Configuration
REQ-029 SHALL implement out-of-range checking under macro MAIN_MEMORY_OOR_CHECK_EN.
REQ-030 SHALL, when MAIN_MEMORY_OOR_CHECK_EN is defined, treat any address with nonzero bits above OFF_W+IDX_W as out of range: resp_err = 1, resp_rdata = 0, and no write or written-bit update.
REQ-031 SHALL, when MAIN_MEMORY_OOR_CHECK_EN is undefined, alias high address bits modulo DEPTH_BLOCKS and tie resp_err to 0.

Structure
REQ-032 SHALL place the FSM state enum, the default parameter constants and the helper function computing OFF_W in package main_memory_pkg.
REQ-033 SHALL put storage and written bits in sub-module main_memory_array (one write port, one read port, synchronous clear of written bits).

Verification (defaults)
REQ-034 SHALL cover: reset, then read 0x0000_0104 -> resp_valid 4 cycles after accept, words 0x100, 0x101, 0x102, 0x103.
REQ-035 SHALL cover: write 0x200 {0xA,0xB,0xC,0xD}, then read 0x20C -> resp_rdata {0xA,0xB,0xC,0xD}, resp_err = 0.
REQ-036 SHALL cover: resp_ready held low 3 cycles in RESP -> resp_valid and data stable, req_ready stays 0, IDLE is entered on the handshake edge.
REQ-037 SHALL cover: read 0x0001_0000 -> with the macro, resp_err = 1 and data 0; without it, aliases block 0 (pattern or stored).
REQ-038 SHALL cover: rst pulsed during WAIT of a write to 0x300 -> no response, and a later read of 0x300 returns the pattern 0x300..0x303.
REQ-039 SHALL cover: req_valid held continuously -> the next accept occurs one cycle after each response handshake; period = LATENCY+2 cycles with resp_ready = 1.
